rle_port_a_arbiter: RTL
=======================

// Module: rle_port_a_arbiter
// PURPOSE
// - Shares the single dpsram port A between two requesters: requester 0 (RLE read
//   engine, plaintext fetch) and requester 1 (RLE write engine, compressed output).
// - Round-robin arbitration with a bounded burst, one access per cycle, zero-bubble
//   handover between requesters.
// - Sits between the RLE datapath and the dpsram.
// - Drives port_A_clk/addr/data_in/we.
// - Returns read data with a per-requester valid strobe.
// PARAMETERS
// - ADDR_W     16  dpsram word-address width (port_A_addr width)
// - DATA_W     32  data width
// - MAX_BURST  4   max consecutive grants to one requester while the other waits (>=1)
// PORTS
// - clk              in   1       system clock; also drives port_A_clk
// - reset            in   1       asynchronous, active-high reset
// - req0 / req1      in   1       access request, held until granted
// - we0 / we1        in   1       1 = write, 0 = read; valid with req
// - addr0 / addr1    in   ADDR_W  word address; valid with req
// - wdata0 / wdata1  in   DATA_W  write data; valid with req & we
// - gnt0 / gnt1      out  1       access performed this cycle (combinational)
// - rvalid0 / rvalid1 out 1       rdata holds read result for that requester (registered)
// - rdata            out  DATA_W  = port_A_data_out, shared; qualified by rvalid0/1
// - port_A_clk       out  1       = clk
// - port_A_addr      out  ADDR_W  address of the granted requester, else 0
// - port_A_data_in   out  DATA_W  wdata of the granted requester, else 0
// - port_A_we        out  1       we of the granted requester, else 0
// - port_A_data_out  in   DATA_W  dpsram read data, 1 cycle after the address cycle
// BEHAVIOUR
// - State owner in {NONE, R0, R1}.
//   - owner is the requester granted in the previous cycle; NONE if that cycle had no grant.
//   - last (1 b) is the most recently granted requester.
//   - bcnt (counts 0..MAX_BURST) is the number of consecutive grants to owner.
// - Reset: owner=NONE, last=1 (so R0 wins the first tie), bcnt=0, rvalid0/1=0.
//   - While reset is high: gnt0/1=0, port_A_we=0, port_A_addr=0, port_A_data_in=0.
// - Grant selection, evaluated each cycle:
//   - no req: no grant.
//   - single req: grant it, regardless of bcnt.
//   - both req, owner=Rx, bcnt<MAX_BURST: grant x (continue burst).
//   - both req, otherwise: grant the requester != last.
// - At most one of gnt0/gnt1 is high; a grant implies the matching req is high.
// - Update on clk:
//   - granted x == owner: bcnt <= bcnt+1, saturating at MAX_BURST.
//   - granted x != owner: owner <= Rx, bcnt <= 1.
//   - any grant: last <= x.
//   - no grant: owner <= NONE, bcnt <= 0, last unchanged.
// - Handover: the losing requester is granted in the cycle immediately after the
//   winner's final burst grant (no idle cycle).
// - Read latency: a granted read (we=0) in cycle N gives rvalidx=1 in cycle N+1, with
//   rdata = port_A_data_out that cycle.
//   - rvalid is a single-cycle pulse per read; back-to-back reads give back-to-back pulses.
//   - Granted writes never raise rvalid.
// - Requester rules:
//   - On gnt, the access is complete (write) or issued (read).
//   - The requester may change addr/we/wdata or drop req in the next cycle.
//   - Dropping req without a grant is legal and has no effect.
// - Starvation bound: a held request is granted within MAX_BURST cycles.
// - Reset asserted mid-burst or with a read in flight:
//   - all state returns to reset values at once; the pending rvalid is lost.
//   - the first cycle after release behaves as after power-up.
// TESTING
// - Reset, req0=1 we0=0 addr0=0x0010 -> gnt0 same cycle, port_A_addr=0x0010,
//   rvalid0=1 next cycle, rdata=mem[0x10].
// - req0 & req1 held continuously, MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0...;
//   never more than 4 consecutive grants.
// - req1 write (we1=1, addr1=0x0200, wdata1=0xDEADBEEF), req0 idle ->
//   port_A_we=1, data_in=0xDEADBEEF; no rvalid; read-back via req0 returns 0xDEADBEEF.
// - Simultaneous first request after reset -> R0 granted; then req0 drops ->
//   R1 granted next cycle, no bubble.
// - Assert reset during R0 burst with a read issued the previous cycle ->
//   gnt0/1, rvalid0, port_A_we = 0 immediately; after release req1 alone is granted.
// - Random req/we/addr for 10k cycles vs scoreboard:
//   - no double grant, no lost access;
//   - every read's rvalid matches its requester;
//   - wait time <= MAX_BURST cycles.

Source files
------------

// File: rtl/rle_port_a_arbiter.sv
// Round-robin arbiter sharing dpsram port A between the RLE read engine (requester 0)
// and the RLE write engine (requester 1), with bounded bursts and zero-bubble handover.
module rle_port_a_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              port_A_clk,
   output logic [ADDR_W-1:0] port_A_addr,
   output logic [DATA_W-1:0] port_A_data_in,
   output logic              port_A_we,
   input  logic [DATA_W-1:0] port_A_data_out
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_R0   = 2'd1,
      OWN_R1   = 2'd2
   } owner_t;

   owner_t             owner;
   owner_t             owner_next;
   owner_t             winner;
   logic               last;
   logic               last_next;
   logic [CNT_W-1:0]   bcnt;
   logic [CNT_W-1:0]   bcnt_next;

   // last resets to 1 so that requester 0 wins the first contested cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner <= OWN_NONE;
         last  <= 1'b1;
         bcnt  <= '0;
      end else begin
         owner <= owner_next;
         last  <= last_next;
         bcnt  <= bcnt_next;
      end
   end

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (req0 && !req1) begin
            gnt0 = 1'b1;
         end else if (req1 && !req0) begin
            gnt1 = 1'b1;
         end else if (req0 && req1) begin
            if (owner == OWN_R0 && bcnt < BURST_LIM) begin
               gnt0 = 1'b1;
            end else if (owner == OWN_R1 && bcnt < BURST_LIM) begin
               gnt1 = 1'b1;
            end else if (last) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end
      end
   end

   always_comb begin
      owner_next = owner;
      last_next  = last;
      bcnt_next  = bcnt;
      winner     = gnt1 ? OWN_R1 : OWN_R0;
      if (!(gnt0 || gnt1)) begin
         owner_next = OWN_NONE;
         bcnt_next  = '0;
      end else begin
         last_next = gnt1;
         if (winner == owner) begin
            bcnt_next = (bcnt == BURST_LIM) ? bcnt : bcnt + 1'b1;
         end else begin
            owner_next = winner;
            bcnt_next  = CNT_W'(1);
         end
      end
   end

   always_comb begin
      port_A_addr    = '0;
      port_A_data_in = '0;
      port_A_we      = 1'b0;
      if (gnt0) begin
         port_A_addr    = addr0;
         port_A_data_in = wdata0;
         port_A_we      = we0;
      end else if (gnt1) begin
         port_A_addr    = addr1;
         port_A_data_in = wdata1;
         port_A_we      = we1;
      end
   end

   // The dpsram returns read data one cycle after the address, so rvalid is the
   // granted-read flag delayed by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= gnt0 & ~we0;
         rvalid1 <= gnt1 & ~we1;
      end
   end

   assign rdata      = port_A_data_out;
   assign port_A_clk = clk;

endmodule
